readonly_cache_axi4_burst_arbiter: RTL and testbench

//  Multi-port, registered successor of the read-only cache-to-AXI4 bridge. Arbitrates

---
 rtl/readonly_cache_axi4_burst_arbiter_if.sv | 57 +++++
 rtl/readonly_cache_axi4_burst_arbiter.sv | 144 ++++++++++++++
 tb/tb_readonly_cache_axi4_burst_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/readonly_cache_axi4_burst_arbiter_if.sv
// Bundle of the cache-side request/beat signals and the AXI4 read channels.
// Port summary:
//   S_AR*   per-port line-fill requests from the caches (packed, port i at [ADDR_W*i +: ADDR_W])
//   S_R*    shared beat data/response, per-port valid/ready, local last, sticky protocol error
//   M_AXI_AR* / M_AXI_R*  AXI4 read-address and read-data channels
// Modports:
//   master : the arbiter (AXI read master, cache-side responder)
//   slave  : the surrounding environment (caches plus AXI interconnect)
interface readonly_cache_axi4_burst_arbiter_if #(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ID_W      = 3
);
   logic [NUM_PORTS*ADDR_W-1:0] S_ARADDR;
   logic [NUM_PORTS-1:0]        S_ARVALID;
   logic [NUM_PORTS-1:0]        S_ARREADY;
   logic [DATA_W-1:0]           S_RDATA;
   logic [1:0]                  S_RRESP;
   logic [NUM_PORTS-1:0]        S_RVALID;
   logic                        S_RLAST;
   logic [NUM_PORTS-1:0]        S_RREADY;
   logic                        S_PROT_ERR;

   logic [ID_W-1:0]             M_AXI_ARID;
   logic [ADDR_W-1:0]           M_AXI_ARADDR;
   logic [7:0]                  M_AXI_ARLEN;
   logic [2:0]                  M_AXI_ARSIZE;
   logic [1:0]                  M_AXI_ARBURST;
   logic                        M_AXI_ARVALID;
   logic                        M_AXI_ARREADY;

   logic [ID_W-1:0]             M_AXI_RID;
   logic [DATA_W-1:0]           M_AXI_RDATA;
   logic [1:0]                  M_AXI_RRESP;
   logic                        M_AXI_RLAST;
   logic                        M_AXI_RVALID;
   logic                        M_AXI_RREADY;

   modport master (
      input  S_ARADDR, S_ARVALID, S_RREADY,
      input  M_AXI_ARREADY,
      input  M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
      output S_ARREADY, S_RDATA, S_RRESP, S_RVALID, S_RLAST, S_PROT_ERR,
      output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
      output M_AXI_RREADY
   );

   modport slave (
      output S_ARADDR, S_ARVALID, S_RREADY,
      output M_AXI_ARREADY,
      output M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
      input  S_ARREADY, S_RDATA, S_RRESP, S_RVALID, S_RLAST, S_PROT_ERR,
      input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
      input  M_AXI_RREADY
   );
endinterface

// File: rtl/readonly_cache_axi4_burst_arbiter.sv
// Round-robin arbiter that turns line-fill requests from NUM_PORTS read-only caches
// into aligned AXI4 INCR read bursts, one burst outstanding at a time. Beats are
// counted locally; RLAST/RID disagreements from the slave raise a sticky error.
// Ports:
//   M_AXI_ACLK     clock, rising edge
//   M_AXI_ARESETN  asynchronous active-low reset
//   bus            readonly_cache_axi4_burst_arbiter_if.master (cache side + AXI4 read)
module readonly_cache_axi4_burst_arbiter #(
   parameter int unsigned NUM_PORTS        = 2,
   parameter int unsigned M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned M_AXI_DATA_WIDTH = 32,
   parameter int unsigned M_AXI_BURST_LEN  = 7,
   parameter int unsigned M_AXI_BURST_SIZE = 2,
   parameter int unsigned M_AXI_ID_WIDTH   = 3
) (
   input logic M_AXI_ACLK,
   input logic M_AXI_ARESETN,
   readonly_cache_axi4_burst_arbiter_if.master bus
);
   localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned BW    = (M_AXI_BURST_LEN > 0) ? $clog2(M_AXI_BURST_LEN + 1) : 1;
   localparam int unsigned OFF_W = $clog2((M_AXI_BURST_LEN + 1) << M_AXI_BURST_SIZE);
   localparam logic [M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK = {M_AXI_ADDR_WIDTH{1'b1}} << OFF_W;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   state_t                      r_state;
   state_t                      w_next;
   logic [PW-1:0]               r_grant;
   logic [M_AXI_ADDR_WIDTH-1:0] r_araddr;
   logic                        r_arvalid;
   logic [BW-1:0]               r_beat;
   logic                        r_prot_err;

   logic [PW-1:0]               w_grant;
   logic                        w_take;
   logic                        w_ar_hs;
   logic                        w_rready;
   logic                        w_r_hs;
   logic                        w_last_beat;
   logic [M_AXI_DATA_WIDTH-1:0] w_rdata;

   // First requesting port strictly after the last granted one, wrapping around.
   function automatic logic [PW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                             input logic [PW-1:0]        last);
      logic [PW-1:0] pick;
      logic          found;
      int unsigned   idx;
      pick  = last;
      found = 1'b0;
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
         idx = (32'(last) + k) % NUM_PORTS;
         if (!found && req[PW'(idx)]) begin
            pick  = PW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign w_grant     = rr_pick(bus.S_ARVALID, r_grant);
   // Reset gating keeps the grant pulse low while reset is held.
   assign w_take      = (r_state == S_IDLE) && (|bus.S_ARVALID) && M_AXI_ARESETN;
   assign w_ar_hs     = r_arvalid && bus.M_AXI_ARREADY;
   assign w_rready    = (r_state == S_DATA) && bus.S_RREADY[r_grant];
   assign w_r_hs      = w_rready && bus.M_AXI_RVALID;
   assign w_last_beat = (r_beat == BW'(M_AXI_BURST_LEN));
   assign w_rdata     = bus.M_AXI_RDATA;

   // State register
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state plus the pass-through outputs of the cache side
   always_comb begin
      w_next        = r_state;
      bus.S_ARREADY = '0;
      bus.S_RVALID  = '0;
      bus.S_RLAST   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_take) begin
               bus.S_ARREADY[w_grant] = 1'b1;
               w_next                 = S_ADDR;
            end
         end
         S_ADDR: begin
            if (w_ar_hs) begin
               w_next = S_DATA;
            end
         end
         S_DATA: begin
            bus.S_RVALID[r_grant] = bus.M_AXI_RVALID;
            bus.S_RLAST           = w_last_beat;
            if (w_r_hs && w_last_beat) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Request capture, AR valid, beat counter and sticky protocol check
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         r_grant    <= PW'(NUM_PORTS - 1);
         r_araddr   <= '0;
         r_arvalid  <= 1'b0;
         r_beat     <= '0;
         r_prot_err <= 1'b0;
      end else begin
         if (w_take) begin
            r_grant  <= w_grant;
            r_araddr <= bus.S_ARADDR[w_grant*M_AXI_ADDR_WIDTH +: M_AXI_ADDR_WIDTH] & ALIGN_MASK;
         end
         r_arvalid <= (w_next == S_ADDR);
         if (w_ar_hs) begin
            r_beat <= '0;
         end else if (w_r_hs) begin
            r_beat <= r_beat + BW'(1);
         end
         if (w_r_hs && ((bus.M_AXI_RLAST != w_last_beat) ||
                        (bus.M_AXI_RID != M_AXI_ID_WIDTH'(r_grant)))) begin
            r_prot_err <= 1'b1;
         end
      end
   end

   assign bus.M_AXI_ARID    = M_AXI_ID_WIDTH'(r_grant);
   assign bus.M_AXI_ARADDR  = r_araddr;
   assign bus.M_AXI_ARLEN   = 8'(M_AXI_BURST_LEN);
   assign bus.M_AXI_ARSIZE  = 3'(M_AXI_BURST_SIZE);
   assign bus.M_AXI_ARBURST = 2'b01;
   assign bus.M_AXI_ARVALID = r_arvalid;
   assign bus.M_AXI_RREADY  = w_rready;
   assign bus.S_RDATA       = w_rdata;
   assign bus.S_RRESP       = bus.M_AXI_RRESP;
   assign bus.S_PROT_ERR    = r_prot_err;
endmodule

// File: tb/tb_readonly_cache_axi4_burst_arbiter.sv
// Directed bench for readonly_cache_axi4_burst_arbiter: drives cache requests and acts
// as the AXI slave; expected beats are queued when a burst is driven and popped on
// each cache-side handshake.
module tb_readonly_cache_axi4_burst_arbiter;
   localparam int unsigned NP     = 2;
   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam int unsigned BL     = 7;
   localparam int unsigned BS     = 2;
   localparam int unsigned IW     = 3;
   localparam int          NBEATS = BL + 1;
   localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   logic  clk = 1'b0;
   logic  rst_n;
   beat_t sb[$];
   int    n_checks = 0;
   int    n_errors = 0;
   logic  m_prot   = 1'b0;
   int    burst_no = 0;

   readonly_cache_axi4_burst_arbiter_if #(
      .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)
   ) bus ();

   readonly_cache_axi4_burst_arbiter #(
      .NUM_PORTS(NP), .M_AXI_ADDR_WIDTH(AW), .M_AXI_DATA_WIDTH(DW),
      .M_AXI_BURST_LEN(BL), .M_AXI_BURST_SIZE(BS), .M_AXI_ID_WIDTH(IW)
   ) dut (
      .M_AXI_ACLK   (clk),
      .M_AXI_ARESETN(rst_n),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.S_ARADDR      = '0;
      bus.S_ARVALID     = '0;
      bus.S_RREADY      = '0;
      bus.M_AXI_ARREADY = 1'b0;
      bus.M_AXI_RID     = '0;
      bus.M_AXI_RDATA   = '0;
      bus.M_AXI_RRESP   = 2'b00;
      bus.M_AXI_RLAST   = 1'b0;
      bus.M_AXI_RVALID  = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " arvalid"},  64'(bus.M_AXI_ARVALID), 64'(0));
      chk({tag, " rready"},   64'(bus.M_AXI_RREADY),  64'(0));
      chk({tag, " s_arready"},64'(bus.S_ARREADY),     64'(0));
      chk({tag, " s_rvalid"}, 64'(bus.S_RVALID),      64'(0));
      chk({tag, " s_rlast"},  64'(bus.S_RLAST),       64'(0));
      chk({tag, " prot_err"}, 64'(bus.S_PROT_ERR),    64'(0));
   endtask

   task automatic raise_req(input int p, input logic [31:0] a);
      bus.S_ARADDR[p*32 +: 32] = a;
      bus.S_ARVALID[p]         = 1'b1;
   endtask

   // Wait for the grant of port p, run its address phase and its 8-beat data phase.
   task automatic serve(input string tag, input int p, input logic [31:0] req_addr,
                        input int exp_wait, input int ar_delay, input bit toggle,
                        input int err_beat, input int rlast_beat, input int abort_beat);
      int          waitc;
      int          beat;
      int          cyc;
      bit          rdy;
      beat_t       e;
      logic [31:0] base;
      waitc = 0;
      #1;
      while (bus.S_ARREADY == '0 && waitc < 30) begin
         @(negedge clk);
         bus.M_AXI_RVALID = 1'b0;
         bus.M_AXI_RLAST  = 1'b0;
         bus.S_RREADY     = '0;
         #1;
         waitc++;
      end
      chk({tag, " grant_seen"}, 64'(bus.S_ARREADY != '0), 64'(1));
      if (bus.S_ARREADY == '0) return;
      chk({tag, " s_arready"},  64'(bus.S_ARREADY),     64'(1 << p));
      chk({tag, " grant_wait"}, 64'(waitc),             64'(exp_wait));
      chk({tag, " arvalid_at_grant"}, 64'(bus.M_AXI_ARVALID), 64'(0));

      // Address phase
      for (int c = 0; c <= ar_delay; c++) begin
         @(negedge clk);
         if (c == 0) bus.S_ARVALID[p] = 1'b0;
         bus.M_AXI_ARREADY = (c == ar_delay);
         #1;
         chk({tag, " arvalid"},   64'(bus.M_AXI_ARVALID), 64'(1));
         chk({tag, " araddr"},    64'(bus.M_AXI_ARADDR),  64'(req_addr & LINE_MASK));
         chk({tag, " arid"},      64'(bus.M_AXI_ARID),    64'(p));
         chk({tag, " arlen"},     64'(bus.M_AXI_ARLEN),   64'(7));
         chk({tag, " arsize"},    64'(bus.M_AXI_ARSIZE),  64'(2));
         chk({tag, " arburst"},   64'(bus.M_AXI_ARBURST), 64'(1));
         chk({tag, " ar_pulse"},  64'(bus.S_ARREADY),     64'(0));
         chk({tag, " ar_rvalid"}, 64'(bus.S_RVALID),      64'(0));
      end

      // Data phase
      base = 32'hC0DE_0000 + 32'(burst_no << 8);
      burst_no++;
      for (int i = 0; i < NBEATS; i++)
         sb.push_back('{data: base + 32'(i), resp: (i == err_beat) ? 2'b10 : 2'b00,
                        last: (i == NBEATS - 1)});
      beat = 0;
      cyc  = 0;
      while (beat < NBEATS && cyc < 40) begin
         @(negedge clk);
         bus.M_AXI_ARREADY = 1'b0;
         bus.M_AXI_RVALID  = 1'b1;
         bus.M_AXI_RDATA   = base + 32'(beat);
         bus.M_AXI_RRESP   = (beat == err_beat) ? 2'b10 : 2'b00;
         bus.M_AXI_RLAST   = (beat == rlast_beat);
         bus.M_AXI_RID     = IW'(p);
         rdy               = toggle ? (cyc % 2 == 0) : 1'b1;
         bus.S_RREADY      = '1;
         bus.S_RREADY[p]   = rdy;
         #1;
         chk({tag, " d_arvalid"}, 64'(bus.M_AXI_ARVALID), 64'(0));
         chk({tag, " d_s_rvalid"},64'(bus.S_RVALID),      64'(1 << p));
         chk({tag, " d_rready"},  64'(bus.M_AXI_RREADY),  64'(rdy));
         chk({tag, " d_prot"},    64'(bus.S_PROT_ERR),    64'(m_prot));
         chk({tag, " d_pulse"},   64'(bus.S_ARREADY),     64'(0));
         if (beat == abort_beat) break;
         if (rdy) begin
            e = sb.pop_front();
            chk({tag, " rdata"}, 64'(bus.S_RDATA), 64'(e.data));
            chk({tag, " rresp"}, 64'(bus.S_RRESP), 64'(e.resp));
            chk({tag, " rlast"}, 64'(bus.S_RLAST), 64'(e.last));
            if ((beat == rlast_beat) != (beat == NBEATS - 1)) m_prot = 1'b1;
            beat++;
         end
         cyc++;
      end
      if (abort_beat < 0) begin
         chk({tag, " beats"},    64'(beat),    64'(NBEATS));
         chk({tag, " sb_empty"}, 64'(sb.size()), 64'(0));
      end
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Two ports contending twice: grants alternate 0,1,0,1
      raise_req(0, 32'h2000_0040);
      raise_req(1, 32'h3000_0088);
      serve("t2a", 0, 32'h2000_0040, 0, 0, 1'b0, -1, 7, -1);
      raise_req(0, 32'h2000_0104);
      serve("t2b", 1, 32'h3000_0088, 1, 0, 1'b0, -1, 7, -1);
      raise_req(1, 32'h3000_01FC);
      serve("t2c", 0, 32'h2000_0104, 1, 0, 1'b0, -1, 7, -1);
      serve("t2d", 1, 32'h3000_01FC, 1, 0, 1'b0, -1, 7, -1);

      // Single port, no stalls, unaligned address
      raise_req(0, 32'h1000_0014);
      serve("t1", 0, 32'h1000_0014, 1, 0, 1'b0, -1, 7, -1);

      // Port 1 with toggling beat ready
      raise_req(1, 32'h4000_0004);
      serve("t4", 1, 32'h4000_0004, 1, 0, 1'b1, -1, 7, -1);

      // AR channel stalled 5 cycles
      raise_req(0, 32'h5000_0100);
      serve("t3", 0, 32'h5000_0100, 1, 5, 1'b0, -1, 7, -1);

      // SLVERR on beat 3 forwarded, burst still completes
      raise_req(1, 32'h6000_0020);
      serve("t5", 1, 32'h6000_0020, 1, 0, 1'b0, 2, 7, -1);

      // Early RLAST on beat 6 then reset mid-burst
      raise_req(0, 32'h7000_003C);
      serve("t6", 0, 32'h7000_003C, 1, 0, 1'b0, -1, 5, 7);
      chk("t6 prot_before_reset", 64'(bus.S_PROT_ERR), 64'(1));
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t6_midreset");
      sb.delete();
      m_prot = 1'b0;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin pointer restarts at port 0 after reset
      raise_req(0, 32'h8000_0000);
      raise_req(1, 32'h9000_0000);
      serve("t7a", 0, 32'h8000_0000, 0, 0, 1'b0, -1, 7, -1);
      serve("t7b", 1, 32'h9000_0000, 1, 0, 1'b0, -1, 7, -1);

      @(negedge clk);
      idle_inputs();
      #1;
      chk("end s_rvalid", 64'(bus.S_RVALID),      64'(0));
      chk("end arvalid",  64'(bus.M_AXI_ARVALID), 64'(0));
      chk("end prot",     64'(bus.S_PROT_ERR),    64'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
